cpu_fetch_buffer: RTL and testbench

CPU_FETCH_BUFFER -- requirements
Module: cpu_fetch_buffer

---
 rtl/cpu_fetch_buffer_pkg.sv | 9 +
 rtl/cpu_fetch_fifo.sv | 82 ++++++++
 rtl/cpu_fetch_buffer.sv | 79 +++++++
 tb/tb_cpu_fetch_buffer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_buffer_pkg.sv
// Shared CPU front-end constants: the NOP encoding and the default fetch buffer depth.
package cpu_fetch_buffer_pkg;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam int          FETCH_DEPTH = 4;

   typedef logic [31:0] word_t;

endpackage

// File: rtl/cpu_fetch_fifo.sv
// Fetch entry storage: tail allocates at grant, fill pointer completes entries in order, head pops.
// Latency: a fill becomes visible at the head one cycle later; the caller must not push when full.
module cpu_fetch_fifo
   import cpu_fetch_buffer_pkg::*;
#(
   parameter  int DEPTH = FETCH_DEPTH,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  word_t         push_pc,
   input  logic          fill,
   input  word_t         fill_data,
   input  logic          pop,
   output logic [CW-1:0] used,
   output logic [CW-1:0] unfilled,
   output logic          head_vld,
   output word_t         head_pc,
   output word_t         head_data
);

   logic [PW-1:0]    wr_ptr, rd_ptr, fill_ptr;
   logic [CW-1:0]    used_q, unfilled_q;
   logic [DEPTH-1:0] filled;
   word_t            pc_mem   [DEPTH];
   word_t            data_mem [DEPTH];
   logic             fill_ok;

   // A fill with nothing outstanding cannot belong to this buffer.
   assign fill_ok = fill && (unfilled_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_ptr   <= '0;
         used_q     <= '0;
         unfilled_q <= '0;
         filled     <= '0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_ptr   <= '0;
         used_q     <= '0;
         unfilled_q <= '0;
         filled     <= '0;
      end else begin
         if (push) begin
            wr_ptr         <= wr_ptr + PW'(1);
            filled[wr_ptr] <= 1'b0;
         end
         if (fill_ok) begin
            fill_ptr         <= fill_ptr + PW'(1);
            filled[fill_ptr] <= 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         used_q     <= used_q + CW'(push) - CW'(pop);
         unfilled_q <= unfilled_q + CW'(push) - CW'(fill_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr] <= push_pc;
      end
      if (fill_ok) begin
         data_mem[fill_ptr] <= fill_data;
      end
   end

   assign used      = used_q;
   assign unfilled  = unfilled_q;
   assign head_vld  = (used_q != '0) && filled[rd_ptr];
   assign head_pc   = pc_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/cpu_fetch_buffer.sv
// Instruction fetch buffer: issues word fetches, buffers in-order responses, drops stale ones after redirect.
// Latency: response cycle N -> instr_valid N+1; requests stop while entries plus pending drops reach DEPTH.
module cpu_fetch_buffer
   import cpu_fetch_buffer_pkg::*;
#(
   parameter int          DEPTH    = FETCH_DEPTH,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_data,
   input  logic        instr_ready
);

   localparam int CW = $clog2(DEPTH + 1);

   word_t         fetch_pc;
   logic [CW-1:0] discard, used, unfilled;
   logic [CW:0]   occupancy;
   logic          grant, drop, fill, pop, head_vld;
   word_t         head_pc, head_data;

   // Pending drops still occupy memory-side slots, so they count against the request budget.
   assign occupancy = {1'b0, used} + {1'b0, discard};
   assign mem_req   = rst_n && !redirect && (occupancy < (CW+1)'(DEPTH));
   assign mem_addr  = fetch_pc;
   assign grant     = mem_req && mem_gnt;
   assign drop      = mem_rvalid && (discard != '0);
   assign fill      = mem_rvalid && !drop && !redirect;
   assign pop       = head_vld && instr_ready && !redirect;

   assign instr_valid = head_vld;
   assign instr_pc    = head_vld ? head_pc   : '0;
   assign instr_data  = head_vld ? head_data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         discard  <= '0;
      end else if (redirect) begin
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         // A response arriving now is either an existing drop or the oldest unfilled entry.
         discard  <= discard + unfilled - CW'(mem_rvalid);
      end else begin
         if (grant) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (drop) begin
            discard <= discard - CW'(1);
         end
      end
   end

   cpu_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect),
      .push      (grant),
      .push_pc   (fetch_pc),
      .fill      (fill),
      .fill_data (mem_rdata),
      .pop       (pop),
      .used      (used),
      .unfilled  (unfilled),
      .head_vld  (head_vld),
      .head_pc   (head_pc),
      .head_data (head_data)
   );

endmodule

// File: tb/tb_cpu_fetch_buffer.sv
// Bench for cpu_fetch_buffer: acts as instruction memory and decode, compares against a queue-based model.
module tb_cpu_fetch_buffer;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic [31:0] instr_pc;
   logic [31:0] instr_data;
   logic        instr_ready;

   cpu_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .instr_valid (instr_valid),
      .instr_pc    (instr_pc),
      .instr_data  (instr_data),
      .instr_ready (instr_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } ins_t;

   // Model: requests in flight at the memory (oldest first), instructions ready for decode,
   // and how many of the oldest in-flight requests were issued before the last redirect.
   req_t        inflight[$];
   ins_t        held[$];
   int          stale;
   logic [31:0] fpc;
   int          cyc;

   int n_checks, n_fail;
   int gnt_pct, lat_lo, lat_hi, rdy_pct, redir_pct;
   int grants_seen;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic set_knobs(input int g, input int lo, input int hi, input int r, input int rd);
      gnt_pct = g; lat_lo = lo; lat_hi = hi; rdy_pct = r; redir_pct = rd;
   endtask

   task automatic model_clear();
      inflight.delete();
      held.delete();
      stale = 0;
      fpc   = RESET_PC;
   endtask

   // Entered and left at posedge+1.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_mem_req",     32'(mem_req),     32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr_pc",    instr_pc,         32'd0);
      chk("rst_instr_data",  instr_data,       32'd0);
      chk("rst_mem_addr",    mem_addr,         RESET_PC);
      redirect    = 1'b0;
      redirect_pc = '0;
      mem_gnt     = 1'b0;
      mem_rvalid  = 1'b0;
      mem_rdata   = '0;
      instr_ready = 1'b0;
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic step(input bit redir, input logic [31:0] rpc);
      bit   exp_req, ev_grant, ev_pop, ev_rv;
      req_t r;
      redirect    = redir;
      redirect_pc = rpc;
      mem_gnt     = ($urandom_range(99) < gnt_pct);
      instr_ready = ($urandom_range(99) < rdy_pct);
      ev_rv       = (inflight.size() > 0) && (inflight[0].due <= cyc);
      mem_rvalid  = ev_rv;
      mem_rdata   = ev_rv ? inflight[0].data : $urandom;

      @(negedge clk);
      exp_req = !redir && ((inflight.size() + held.size()) < DEPTH);
      chk("mem_req",     32'(mem_req),     32'(exp_req));
      chk("mem_addr",    mem_addr,         fpc);
      chk("instr_valid", 32'(instr_valid), 32'(held.size() > 0));
      if (held.size() > 0) begin
         chk("instr_pc",   instr_pc,   held[0].pc);
         chk("instr_data", instr_data, held[0].data);
      end else begin
         chk("instr_pc_idle",   instr_pc,   32'd0);
         chk("instr_data_idle", instr_data, 32'd0);
      end
      if (mem_req && mem_gnt) grants_seen++;
      ev_grant = exp_req && mem_gnt;
      ev_pop   = (held.size() > 0) && instr_ready && !redir;

      @(posedge clk);
      if (ev_rv) begin
         r = inflight.pop_front();
         if (stale > 0) stale--;
         else if (!redir) held.push_back('{r.addr, r.data});
      end
      if (redir) begin
         held.delete();
         stale = inflight.size();
         fpc   = {rpc[31:2], 2'b00};
      end else begin
         if (ev_pop) void'(held.pop_front());
         if (ev_grant) begin
            inflight.push_back('{fpc, $urandom, cyc + int'($urandom_range(lat_hi, lat_lo))});
            fpc = fpc + 32'd4;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step($urandom_range(99) < redir_pct, $urandom);
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0; cyc = 0; grants_seen = 0;
      set_knobs(100, 1, 1, 100, 0);
      #1;
      do_reset();

      // Zero-wait memory, decode always ready.
      set_knobs(100, 1, 1, 100, 0);
      run(20);

      // Decode stalled: buffer fills to DEPTH and requests stop.
      do_reset();
      set_knobs(100, 1, 1, 0, 0);
      grants_seen = 0;
      run(10);
      chk("grants_while_stalled", grants_seen, DEPTH);
      set_knobs(100, 1, 1, 100, 0);
      run(10);

      // Three outstanding slow fetches, then redirect to 0x100.
      do_reset();
      set_knobs(100, 5, 5, 100, 0);
      run(3);
      step(1'b1, 32'h0000_0100);
      set_knobs(100, 1, 1, 100, 0);
      run(15);

      // Redirect in the same cycle as a response.
      do_reset();
      set_knobs(100, 2, 2, 100, 0);
      run(2);
      step(1'b1, 32'h0000_0300);
      run(10);

      // Unaligned redirect target and address wrap.
      set_knobs(100, 1, 2, 100, 0);
      step(1'b1, 32'h0000_0203);
      run(3);
      step(1'b1, 32'hFFFF_FFF9);
      run(6);

      // Random traffic with a reset pulse mid-stream.
      set_knobs(60, 1, 4, 70, 3);
      run(1500);
      do_reset();
      set_knobs(30, 1, 3, 40, 5);
      run(1500);
      set_knobs(90, 1, 2, 90, 1);
      run(500);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
